hs32_fetch: RTL

Instruction fetch unit for the HS32 core; the producer end of the fetch-to-decode handshake (instd/reqd/ackd) that hs32_decode consumes. It issues word reads to instruction memory and buffers returned words with their PCs in a small FIFO. It delivers one instruction per accepted request to decode. Execute can redirect it with a PC load, which flushes all buffered and in-flight words.

---
 rtl/hs32_fetch.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: single-outstanding word reads into a prefetch FIFO.
// Optional stall counter output perf_stall when HS32_FETCH_PERF_EN is defined.
module hs32_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqd,
    output logic        ackd,
    output logic [31:0] instd,
    output logic [31:0] instpc,
    input  logic        ldpc,
    input  logic [31:0] newpc,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_dtr
`ifdef HS32_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        ackd_q, ackd_d;
    logic [31:0] instd_q, instd_d;
    logic [31:0] instpc_q, instpc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0] fifo_data_q [DEPTH];
    logic [31:0] fifo_data_d [DEPTH];
    logic [31:0] fifo_pc_q [DEPTH];
    logic [31:0] fifo_pc_d [DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] redirect_pc;

    assign redirect_pc = newpc & ~32'h3;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        ackd_d      = 1'b0;
        instd_d     = instd_q;
        instpc_d    = instpc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        push        = (state_q == REQ) && mem_ack;
        pop         = reqd && (count_q != '0);

        if (ldpc) begin
            // Redirect wins: drop buffered words and any data arriving now.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pc_d     = redirect_pc;
            if (state_q != IDLE && !mem_ack) begin
                state_d = FLUSH;
            end else begin
                state_d    = REQ;
                mem_req_d  = 1'b1;
                mem_addr_d = redirect_pc;
            end
        end else begin
            if (pop) begin
                ackd_d   = 1'b1;
                instd_d  = fifo_data_q[rd_ptr_q];
                instpc_d = fifo_pc_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push) begin
                fifo_data_d[wr_ptr_q] = mem_dtr;
                fifo_pc_d[wr_ptr_q]   = mem_addr_q;
                wr_ptr_d              = wr_ptr_q + AW'(1);
                pc_d                  = pc_q + 32'd4;
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

            unique case (state_q)
                IDLE: begin
                    if (count_d < FULL) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (count_d < FULL) begin
                            mem_addr_d = pc_d;
                        end else begin
                            state_d   = IDLE;
                            mem_req_d = 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // Stale word retired; FIFO is empty so issue right away.
                    if (mem_ack) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_VEC;
            ackd_q     <= 1'b0;
            instd_q    <= '0;
            instpc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            ackd_q      <= ackd_d;
            instd_q     <= instd_d;
            instpc_q    <= instpc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

    assign ackd     = ackd_q;
    assign instd    = instd_q;
    assign instpc   = instpc_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

`ifdef HS32_FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (reqd && count_q == '0 && !ldpc) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = perf_q;
`endif

endmodule
